// File: rtl/v_lane_subtractor_if.sv
// Request/response bundle for v_lane_subtractor: operands and sideband in,
// packed per-byte difference word plus aligned operands out, valid/ready on both sides.
interface v_lane_subtractor_if #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int SEW_WIDTH      = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic [REQ_DATA_WIDTH-1:0]   vec0;
  logic [REQ_DATA_WIDTH-1:0]   vec1;
  logic [SEW_WIDTH-1:0]        sew;
  logic                        is_signed;
  logic                        reverse;
  logic                        minMax_sel_in;

  logic                        out_valid;
  logic                        out_ready;
  logic [REQ_DATA_WIDTH+16:0]  sub_result;
  logic [REQ_DATA_WIDTH-1:0]   vec0_out;
  logic [REQ_DATA_WIDTH-1:0]   vec1_out;
  logic [SEW_WIDTH-1:0]        sew_out;
  logic                        minMax_sel;

  modport master (
    output in_valid, vec0, vec1, sew, is_signed, reverse, minMax_sel_in, out_ready,
    input  in_ready, out_valid, sub_result, vec0_out, vec1_out, sew_out, minMax_sel
  );

  modport slave (
    input  in_valid, vec0, vec1, sew, is_signed, reverse, minMax_sel_in, out_ready,
    output in_ready, out_valid, sub_result, vec0_out, vec1_out, sew_out, minMax_sel
  );
endinterface

// File: rtl/v_lane_subtractor.sv
// SEW-segmented carry-select subtractor, 2-stage valid/ready pipe (accept cycle N -> out_valid N+2);
// each stage holds until downstream takes it, in_ready follows out_ready combinationally.
module v_lane_subtractor #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int SEW_WIDTH      = 2,
  parameter int REQ_BE_WIDTH   = REQ_DATA_WIDTH / 8,
  parameter bit ENABLE_64_BIT  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  v_lane_subtractor_if.slave io
);
  localparam int RW = REQ_DATA_WIDTH + 17;
  localparam int BE = REQ_BE_WIDTH;

  // Stage 1 state
  logic                          s1_vld_q,  s1_vld_d;
  logic [REQ_DATA_WIDTH-1:0]     s1_vec0_q, s1_vec0_d;
  logic [REQ_DATA_WIDTH-1:0]     s1_vec1_q, s1_vec1_d;
  logic [SEW_WIDTH-1:0]          s1_sew_q,  s1_sew_d;
  logic                          s1_mm_q,   s1_mm_d;
  logic [BE-1:0]                 s1_xs_q,   s1_xs_d;
  logic [BE-1:0]                 s1_ys_q,   s1_ys_d;
  logic [BE-1:0][8:0]            s1_d0_q,   s1_d0_d;
  logic [BE-1:0][8:0]            s1_d1_q,   s1_d1_d;

  // Stage 2 state (drives the outputs directly)
  logic                          s2_vld_q,  s2_vld_d;
  logic [RW-1:0]                 s2_res_q,  s2_res_d;
  logic [REQ_DATA_WIDTH-1:0]     s2_vec0_q, s2_vec0_d;
  logic [REQ_DATA_WIDTH-1:0]     s2_vec1_q, s2_vec1_d;
  logic [SEW_WIDTH-1:0]          s2_sew_q,  s2_sew_d;
  logic                          s2_mm_q,   s2_mm_d;

  logic                          s2_adv;
  logic                          in_rdy;
  logic                          accept;

  logic [BE-1:0][7:0]            byte_x;
  logic [BE-1:0][7:0]            byte_y;
  logic [BE-1:0][8:0]            byte_d0;
  logic [BE-1:0][8:0]            byte_d1;
  logic [BE-1:0]                 byte_xs;
  logic [BE-1:0]                 byte_ys;

  logic [1:0]                    esew;
  logic [2:0]                    lane_mask;
  logic                          borrow;
  logic                          bin;
  logic                          lane_low;
  logic                          lane_top;
  logic [8:0]                    sel;
  logic [RW-1:0]                 res_c;

  // Per-byte differences for both borrow-in values; the sign bits only matter at element tops.
  always_comb begin
    byte_x  = '0;
    byte_y  = '0;
    byte_d0 = '0;
    byte_d1 = '0;
    byte_xs = '0;
    byte_ys = '0;
    for (int i = 0; i < BE; i++) begin
      byte_x[i]  = io.reverse ? io.vec1[8*i +: 8] : io.vec0[8*i +: 8];
      byte_y[i]  = io.reverse ? io.vec0[8*i +: 8] : io.vec1[8*i +: 8];
      byte_d0[i] = {1'b0, byte_x[i]} - {1'b0, byte_y[i]};
      byte_d1[i] = {1'b0, byte_x[i]} - {1'b0, byte_y[i]} - 9'd1;
      byte_xs[i] = io.is_signed & byte_x[i][7];
      byte_ys[i] = io.is_signed & byte_y[i][7];
    end
  end

  // SEW=64 folds to 32-bit elements unless enabled and the datapath is wide enough.
  always_comb begin
    esew = s1_sew_q[1:0];
    if (s1_sew_q[1:0] == 2'd3 && (!ENABLE_64_BIT || REQ_DATA_WIDTH == 32)) begin
      esew = 2'd2;
    end
    lane_mask = 3'((4'd1 << esew) - 4'd1);
  end

  // Borrow chain restarts at each element's lowest byte; the top byte carries D[SEW].
  always_comb begin
    res_c    = '0;
    borrow   = 1'b0;
    bin      = 1'b0;
    lane_low = 1'b0;
    lane_top = 1'b0;
    sel      = '0;
    for (int i = 0; i < BE; i++) begin
      lane_low = ((3'(i) & lane_mask) == 3'd0);
      lane_top = ((3'(i) & lane_mask) == lane_mask);
      bin      = lane_low ? 1'b0 : borrow;
      sel      = bin ? s1_d1_q[i] : s1_d0_q[i];
      borrow   = sel[8];
      res_c[10*i +: 10] = {lane_top ? (s1_xs_q[i] ^ s1_ys_q[i] ^ sel[8]) : sel[8],
                           sel[7:0], 1'b0};
    end
  end

  always_comb begin
    s2_adv = !s2_vld_q | io.out_ready;
    in_rdy = !s1_vld_q | s2_adv;
    accept = io.in_valid & in_rdy;

    s1_vld_d  = s1_vld_q;
    s1_vec0_d = s1_vec0_q;
    s1_vec1_d = s1_vec1_q;
    s1_sew_d  = s1_sew_q;
    s1_mm_d   = s1_mm_q;
    s1_xs_d   = s1_xs_q;
    s1_ys_d   = s1_ys_q;
    s1_d0_d   = s1_d0_q;
    s1_d1_d   = s1_d1_q;
    s2_vld_d  = s2_vld_q;
    s2_res_d  = s2_res_q;
    s2_vec0_d = s2_vec0_q;
    s2_vec1_d = s2_vec1_q;
    s2_sew_d  = s2_sew_q;
    s2_mm_d   = s2_mm_q;

    if (in_rdy) begin
      s1_vld_d = io.in_valid;
    end
    if (accept) begin
      s1_vec0_d = io.vec0;
      s1_vec1_d = io.vec1;
      s1_sew_d  = io.sew;
      s1_mm_d   = io.minMax_sel_in;
      s1_xs_d   = byte_xs;
      s1_ys_d   = byte_ys;
      s1_d0_d   = byte_d0;
      s1_d1_d   = byte_d1;
    end
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
    end
    if (s2_adv && s1_vld_q) begin
      s2_res_d  = res_c;
      s2_vec0_d = s1_vec0_q;
      s2_vec1_d = s1_vec1_q;
      s2_sew_d  = s1_sew_q;
      s2_mm_d   = s1_mm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_vec0_q <= '0;
      s1_vec1_q <= '0;
      s1_sew_q  <= '0;
      s1_mm_q   <= 1'b0;
      s1_xs_q   <= '0;
      s1_ys_q   <= '0;
      s1_d0_q   <= '0;
      s1_d1_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_res_q  <= '0;
      s2_vec0_q <= '0;
      s2_vec1_q <= '0;
      s2_sew_q  <= '0;
      s2_mm_q   <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_vec0_q <= s1_vec0_d;
      s1_vec1_q <= s1_vec1_d;
      s1_sew_q  <= s1_sew_d;
      s1_mm_q   <= s1_mm_d;
      s1_xs_q   <= s1_xs_d;
      s1_ys_q   <= s1_ys_d;
      s1_d0_q   <= s1_d0_d;
      s1_d1_q   <= s1_d1_d;
      s2_vld_q  <= s2_vld_d;
      s2_res_q  <= s2_res_d;
      s2_vec0_q <= s2_vec0_d;
      s2_vec1_q <= s2_vec1_d;
      s2_sew_q  <= s2_sew_d;
      s2_mm_q   <= s2_mm_d;
    end
  end

  assign io.in_ready   = in_rdy & !rst;
  assign io.out_valid  = s2_vld_q;
  assign io.sub_result = s2_res_q;
  assign io.vec0_out   = s2_vec0_q;
  assign io.vec1_out   = s2_vec1_q;
  assign io.sew_out    = s2_sew_q;
  assign io.minMax_sel = s2_mm_q;
endmodule

// File: tb/tb_v_lane_subtractor.sv
// Scoreboarded bench: two DUTs (64-bit SEW disabled/enabled) in lockstep, random and directed requests.
module tb_v_lane_subtractor;
  localparam int DW = 64;
  localparam int RW = DW + 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v_lane_subtractor_if #(.REQ_DATA_WIDTH(DW), .SEW_WIDTH(2)) if0 ();
  v_lane_subtractor_if #(.REQ_DATA_WIDTH(DW), .SEW_WIDTH(2)) if1 ();

  v_lane_subtractor #(.REQ_DATA_WIDTH(DW), .SEW_WIDTH(2), .REQ_BE_WIDTH(DW/8), .ENABLE_64_BIT(1'b0))
    dut0 (.clk(clk), .rst(rst), .io(if0.slave));
  v_lane_subtractor #(.REQ_DATA_WIDTH(DW), .SEW_WIDTH(2), .REQ_BE_WIDTH(DW/8), .ENABLE_64_BIT(1'b1))
    dut1 (.clk(clk), .rst(rst), .io(if1.slave));

  typedef struct {
    logic [RW-1:0] res;
    logic [DW-1:0] v0;
    logic [DW-1:0] v1;
    logic [1:0]    sew;
    logic          mm;
    logic [RW-1:0] mask;
    logic [RW-1:0] val;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rand_rdy = 1'b0;

  logic          prev_stall [2];
  logic [RW-1:0] prev_res   [2];
  logic [DW-1:0] prev_v0    [2];
  logic [DW-1:0] prev_v1    [2];
  logic [1:0]    prev_sew   [2];
  logic          prev_mm    [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: whole-element arithmetic on (SEW+1)-bit values; non-top borrow = low-part compare.
  function automatic logic [RW-1:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] sew, input logic sg, input logic rv,
                                          input bit en64);
    logic [RW-1:0] r;
    logic [63:0]   xa, ya, xv, yv, lm;
    logic [64:0]   xe, ye, d;
    int            w, lane;
    r  = '0;
    w  = 8 << sew;
    if (w == 64 && !en64) w = 32;
    xa = rv ? b : a;
    ya = rv ? a : b;
    for (int e = 0; e < 64 / w; e++) begin
      xv = xa >> (e * w);
      yv = ya >> (e * w);
      if (w < 64) begin
        xv = xv & ((64'd1 << w) - 64'd1);
        yv = yv & ((64'd1 << w) - 64'd1);
      end
      xe = {1'b0, xv};
      ye = {1'b0, yv};
      if (sg) begin
        xe[w] = xv[w-1];
        ye[w] = yv[w-1];
      end
      d = xe - ye;
      for (int j = 0; j < w / 8; j++) begin
        lane = e * (w / 8) + j;
        r[10*lane+1 +: 8] = d[8*j +: 8];
        if (j == w / 8 - 1) begin
          r[10*lane+9] = d[w];
        end else begin
          lm = (64'd1 << (8 * (j + 1))) - 64'd1;
          r[10*lane+9] = ((xv & lm) < (yv & lm));
        end
      end
    end
    return r;
  endfunction

  task automatic set_in(input logic vld, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] sew, input logic sg, input logic rv, input logic mm);
    if0.in_valid = vld; if0.vec0 = a; if0.vec1 = b; if0.sew = sew;
    if0.is_signed = sg; if0.reverse = rv; if0.minMax_sel_in = mm;
    if1.in_valid = vld; if1.vec0 = a; if1.vec1 = b; if1.sew = sew;
    if1.is_signed = sg; if1.reverse = rv; if1.minMax_sel_in = mm;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sew,
                      input logic sg, input logic rv, input logic mm,
                      input logic [RW-1:0] m0, input logic [RW-1:0] v0,
                      input logic [RW-1:0] m1, input logic [RW-1:0] v1);
    exp_t e;
    set_in(1'b1, a, b, sew, sg, rv, mm);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (if0.in_ready) break;
      if (t > 200) begin
        $display("FAIL accept_timeout: in_ready stuck at %0b, required 1", if0.in_ready);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "accept timeout");
      end
    end
    e.v0 = a; e.v1 = b; e.sew = sew; e.mm = mm;
    e.res = model(a, b, sew, sg, rv, 1'b0); e.mask = m0; e.val = v0;
    q0.push_back(e);
    e.res = model(a, b, sew, sg, rv, 1'b1); e.mask = m1; e.val = v1;
    q1.push_back(e);
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [63:0] a, b;
    a = {$urandom, $urandom};
    b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
    send(a, b, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
         '0, '0, '0, '0);
  endtask

  task automatic check_out(input int k, input logic vld, input logic rdy, input logic [RW-1:0] res,
                           input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                           input logic [1:0] s, input logic mm);
    exp_t e;
    if (prev_stall[k]) begin
      total++;
      if (!vld || res !== prev_res[k] || v0 !== prev_v0[k] || v1 !== prev_v1[k] ||
          s !== prev_sew[k] || mm !== prev_mm[k]) begin
        bad++;
        $display("FAIL stall_hold dut%0d: valid=%0b res=%h, required valid=1 res=%h",
                 k, vld, res, prev_res[k]);
      end
    end
    prev_stall[k] = vld & !rdy;
    prev_res[k] = res; prev_v0[k] = v0; prev_v1[k] = v1; prev_sew[k] = s; prev_mm[k] = mm;
    if (vld && rdy) begin
      total++;
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        bad++;
        $display("FAIL unexpected_output dut%0d: got res=%h, required no output", k, res);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        if (res !== e.res || v0 !== e.v0 || v1 !== e.v1 || s !== e.sew || mm !== e.mm) begin
          bad++;
          $display("FAIL result dut%0d: got res=%h v0=%h v1=%h sew=%0d mm=%0b, required res=%h v0=%h v1=%h sew=%0d mm=%0b",
                   k, res, v0, v1, s, mm, e.res, e.v0, e.v1, e.sew, e.mm);
        end
        if (e.mask != '0) begin
          total++;
          if ((res & e.mask) !== e.val) begin
            bad++;
            $display("FAIL spot dut%0d: got %h, required %h (mask %h)", k, res & e.mask, e.val, e.mask);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      check_out(0, if0.out_valid, if0.out_ready, if0.sub_result, if0.vec0_out, if0.vec1_out,
                if0.sew_out, if0.minMax_sel);
      check_out(1, if1.out_valid, if1.out_ready, if1.sub_result, if1.vec0_out, if1.vec1_out,
                if1.sew_out, if1.minMax_sel);
    end
  end

  initial begin
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if0.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if1.out_ready = if0.out_ready;
    end
  end

  task automatic expect_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0b, required %0b", name, got, want);
    end
  endtask

  initial begin
    logic [RW-1:0] m_all, b79, b39;
    m_all = '0;
    m_all[79:0] = '1;
    b79 = RW'(1) << 79;
    b39 = RW'(1) << 39;
    set_in(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      expect_bit("reset_out_valid0", if0.out_valid, 1'b0);
      expect_bit("reset_out_valid1", if1.out_valid, 1'b0);
      expect_bit("reset_in_ready", if0.in_ready, 1'b0);
      expect_bit("reset_sub_result_zero", (if0.sub_result == '0), 1'b1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_bit("post_reset_in_ready", if0.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Latency: lane 0 field 0x004
    send(64'h05, 64'h03, 2'd0, 1'b0, 1'b0, 1'b1, RW'(10'h3FF), RW'(10'h004), RW'(10'h3FF), RW'(10'h004));
    @(negedge clk);
    expect_bit("latency_n1_idle", if0.out_valid, 1'b0);
    @(negedge clk);
    expect_bit("latency_n2_valid", if0.out_valid, 1'b1);
    @(posedge clk);
    #1;

    send(64'h80, 64'h01, 2'd0, 1'b1, 1'b0, 1'b0, RW'(10'h3FE), RW'(10'h2FE), RW'(10'h3FE), RW'(10'h2FE));
    send(64'h80, 64'h01, 2'd0, 1'b0, 1'b0, 1'b0, RW'(10'h3FE), RW'(10'h0FE), RW'(10'h3FE), RW'(10'h0FE));
    send(64'h0100, 64'h00FF, 2'd1, 1'b0, 1'b0, 1'b0,
         RW'(20'hFFDFE), RW'(20'h00002), RW'(20'hFFDFE), RW'(20'h00002));
    send(64'hDEADBEEF_DEADBEEF, 64'hDEADBEEF_DEADBEEF, 2'd2, 1'b1, 1'b0, 1'b0, m_all, '0, m_all, '0);
    send(64'hDEADBEEF_DEADBEEF, 64'hDEADBEEF_DEADBEEF, 2'd2, 1'b1, 1'b1, 1'b1, m_all, '0, m_all, '0);
    send(64'h0, 64'h1, 2'd3, 1'b0, 1'b0, 1'b0, b79 | b39, b39, b79, b79);

    rand_rdy = 1'b1;
    for (int n = 0; n < 20; n++) send_rand();

    // Mid-stream reset: in-flight entries are dropped on both sides.
    for (int n = 0; n < 6; n++) send_rand();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    expect_bit("midreset_out_valid0", if0.out_valid, 1'b0);
    expect_bit("midreset_out_valid1", if1.out_valid, 1'b0);
    expect_bit("midreset_in_ready", if0.in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) send_rand();
    rand_rdy = 1'b0;

    for (int t = 0; t < 500 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge clk);
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
